// File: rtl/vga_text_renderer.sv
// vga_text_renderer: four-stage text-mode pixel pipeline behind the 1280x1024 VGA sync generator.
// Maps line/column to text-buffer and font-ROM lookups, then emits palette RGB with syncs delayed to match.
module vga_text_renderer #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 1024,
  parameter int BLINK_BITS = 5
) (
  input  logic        clk108,
  input  logic        reset,
  input  logic [11:0] line,
  input  logic [11:0] column,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [13:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [5:0]  cursor_row,
  input  logic [7:0]  cursor_col,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [11:0] H_LIMIT = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIMIT = 12'(V_ACTIVE);

  // Per-pixel side information that travels alongside the memory lookups.
  typedef struct packed {
    logic       active;
    logic [2:0] col3;
    logic [3:0] row4;
    logic       cur;
    logic       hs;
    logic       vs;
  } stage_t;

  localparam stage_t STAGE_RESET = '{
    active: 1'b0,
    col3:   3'd0,
    row4:   4'd0,
    cur:    1'b0,
    hs:     1'b1,
    vs:     1'b1
  };

  function automatic logic [3:0] chan_level(input logic intense, input logic on);
    if (intense) return on ? 4'hF : 4'h5;
    else         return on ? 4'hA : 4'h0;
  endfunction

  // 16-colour palette, index bits {I,R,G,B}; index 6 is dimmed to brown.
  function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    r = chan_level(idx[3], idx[2]);
    g = chan_level(idx[3], idx[1]);
    b = chan_level(idx[3], idx[0]);
    if (idx == 4'd6) g = 4'h5;
    return {r, g, b};
  endfunction

  logic [5:0]            crow;
  logic [7:0]            ccol;
  logic                  pix_active;
  logic                  cursor_hit;
  logic                  blink_on;
  logic                  vs_fall;
  logic [BLINK_BITS-1:0] frame_cnt;

  stage_t      s1_next;
  stage_t      s1;
  stage_t      s2;
  stage_t      s3;
  logic [3:0]  s2_fg;
  logic [3:0]  s2_bg;
  logic [3:0]  s3_fg;
  logic [3:0]  s3_bg;
  logic        pix;
  logic [11:0] rgb_next;
  logic [11:0] rgb;

  assign crow = line[9:4];
  assign ccol = column[10:3];

  // crow*160 as two shifts; max 63*160+255 fits in 14 bits, so no wrap outside the active area.
  assign char_addr = {1'b0, crow, 7'b0} + {3'b0, crow, 5'b0} + {6'b0, ccol};

  assign pix_active = (column < H_LIMIT) && (line < V_LIMIT);
  assign cursor_hit = (crow == cursor_row) && (ccol == cursor_col);
  assign blink_on   = ~frame_cnt[BLINK_BITS-1];
  assign vs_fall    = s1.vs & ~vsync_in;

  always_comb begin
    s1_next = STAGE_RESET;
    s1_next.active = pix_active;
    s1_next.col3   = column[2:0];
    s1_next.row4   = line[3:0];
    s1_next.cur    = cursor_hit && cursor_en && blink_on;
    s1_next.hs     = hsync_in;
    s1_next.vs     = vsync_in;
  end

  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (vs_fall) begin
      frame_cnt <= frame_cnt + {{(BLINK_BITS-1){1'b0}}, 1'b1};
    end
  end

  // S1: side info captured while the text RAM registers char_addr.
  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      s1 <= STAGE_RESET;
    end else begin
      s1 <= s1_next;
    end
  end

  // S2: text word arrives; launch the font lookup and keep the colour indices.
  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      s2        <= STAGE_RESET;
      s2_fg     <= 4'd0;
      s2_bg     <= 4'd0;
      font_addr <= 12'd0;
    end else begin
      s2        <= s1;
      s2_fg     <= char_data[11:8];
      s2_bg     <= char_data[15:12];
      font_addr <= {char_data[7:0], s1.row4};
    end
  end

  // S3: font ROM access in flight.
  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      s3    <= STAGE_RESET;
      s3_fg <= 4'd0;
      s3_bg <= 4'd0;
    end else begin
      s3    <= s2;
      s3_fg <= s2_fg;
      s3_bg <= s2_bg;
    end
  end

  // Cursor is an underline on the bottom two glyph rows.
  always_comb begin
    pix = font_data[3'd7 - s3.col3];
    if (s3.cur && (s3.row4 >= 4'd14)) pix = 1'b1;
    rgb_next = s3.active ? palette_rgb(pix ? s3_fg : s3_bg) : 12'h000;
  end

  // S4: output register, colour and sync leave together.
  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= rgb_next;
      hsync <= s3.hs;
      vsync <= s3.vs;
    end
  end

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed checks of the text renderer against a behavioural
// text RAM and font ROM, with hand-derived colours and sync values per driven pixel.
`timescale 1ns/1ps
module tb_vga_text_renderer;

  localparam int W = 14;  // {hsync, vsync, rgb}

  logic        clk108 = 1'b0;
  logic        reset;
  logic [11:0] line;
  logic [11:0] column;
  logic        hsync_in;
  logic        vsync_in;
  logic [13:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [5:0]  cursor_row;
  logic [7:0]  cursor_col;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;

  logic [15:0]  text_mem [0:16383];
  logic [7:0]   font_mem [0:4095];
  logic [11:0]  glyph_exp [0:7];
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  vga_text_renderer #(
    .H_ACTIVE   (1280),
    .V_ACTIVE   (1024),
    .BLINK_BITS (5)
  ) dut (
    .clk108     (clk108),
    .reset      (reset),
    .line       (line),
    .column     (column),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .cursor_en  (cursor_en),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  // Clock / reset block
  always #5 clk108 = ~clk108;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Synchronous memories, one cycle read latency each.
  always @(posedge clk108) begin
    char_data <= text_mem[char_addr];
    font_data <= font_mem[font_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // After reset the output register shows three more black, sync-high cycles.
  task automatic seed_tail();
    exp_q.delete();
    tag_q.delete();
    repeat (3) begin
      exp_q.push_back({1'b1, 1'b1, 12'h000});
      tag_q.push_back("reset_tail");
    end
  endtask

  // Driver: apply one pixel at the falling edge, score the pixel launched four edges earlier.
  task automatic drive(input logic [11:0] l, input logic [11:0] c, input logic hs,
                       input logic vs, input logic [11:0] rgb_exp, input string tag);
    logic [W-1:0] e;
    string        t;
    line     = l;
    column   = c;
    hsync_in = hs;
    vsync_in = vs;
    exp_q.push_back({hs, vs, rgb_exp});
    tag_q.push_back(tag);
    @(posedge clk108);
    @(negedge clk108);
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {18'd0, hsync, vsync, red, green, blue}, {18'd0, e});
    end
  endtask

  task automatic probe_addr(input logic [11:0] l, input logic [11:0] c,
                            input logic [13:0] exp, input string tag);
    line   = l;
    column = c;
    #1;
    check(tag, {18'd0, char_addr}, {18'd0, exp});
  endtask

  task automatic vs_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      drive(12'd1030, 12'd1300, 1'b1, 1'b0, 12'h000, "vs_tick");
      drive(12'd1030, 12'd1300, 1'b1, 1'b1, 12'h000, "vs_idle");
    end
  endtask

  // Cursor cell is (63,159); neighbouring cell 158 and glyph row 13 stay background.
  task automatic cursor_frame(input logic shown, input string pfx);
    logic [11:0] e;
    for (int l = 1021; l <= 1023; l++) begin
      for (int c = 1271; c <= 1279; c++) begin
        e = (shown && l >= 1022 && c >= 1272) ? 12'hFFF : 12'h000;
        drive(12'(l), 12'(c), 1'b1, 1'b1, e, $sformatf("%s_l%0d_c%0d", pfx, l, c));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) text_mem[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;
    text_mem[325]     = 16'h1E41;
    font_mem[12'h413] = 8'b0110_0110;
    text_mem[0]       = 16'h0FFF;
    text_mem[159]     = 16'h0FFF;
    text_mem[160]     = 16'h0FFF;
    font_mem[12'hFF0] = 8'hFF;
    text_mem[10239]   = 16'h0F00;
    glyph_exp = '{12'h00A, 12'hFF5, 12'hFF5, 12'h00A, 12'h00A, 12'hFF5, 12'hFF5, 12'h00A};

    reset      = 1'b1;
    line       = 12'd0;
    column     = 12'd0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    cursor_en  = 1'b0;
    cursor_row = 6'd0;
    cursor_col = 8'd0;
    repeat (3) @(negedge clk108);
    check("rst_rgb", {20'd0, red, green, blue}, 32'h000);
    check("rst_sync", {30'd0, hsync, vsync}, 32'h3);
    check("rst_font_addr", {20'd0, font_addr}, 32'h0);
    reset = 1'b0;
    seed_tail();

    probe_addr(12'd1023, 12'd1279, 14'd10239, "addr_max");
    probe_addr(12'd0, 12'd0, 14'd0, "addr_zero");
    probe_addr(12'd35, 12'd40, 14'd325, "addr_glyph");
    probe_addr(12'd1065, 12'd1687, 14'd530, "addr_wrap_corner");

    for (int i = 0; i < 8; i++) begin
      drive(12'd35, 12'(40 + i), 1'b1, 1'b1, glyph_exp[i], $sformatf("glyph_c%0d", 40 + i));
      if (i == 1) check("font_addr_glyph", {20'd0, font_addr}, 32'h413);
    end

    drive(12'd0, 12'd1279, 1'b1, 1'b1, 12'hFFF, "edge_c1279");
    drive(12'd0, 12'd1280, 1'b1, 1'b1, 12'h000, "blank_c1280");
    drive(12'd1024, 12'd0, 1'b1, 1'b1, 12'h000, "blank_l1024");
    drive(12'd0, 12'd0, 1'b1, 1'b1, 12'hFFF, "line0_c0");

    for (int c = 1320; c <= 1445; c++)
      drive(12'd0, 12'(c), (c >= 1328 && c < 1440) ? 1'b0 : 1'b1, 1'b1, 12'h000,
            $sformatf("hsync_c%0d", c));
    for (int l = 1024; l <= 1028; l++)
      for (int c = 0; c < 2; c++)
        drive(12'(l), 12'(c), 1'b1, (l >= 1025 && l < 1028) ? 1'b0 : 1'b1, 12'h000,
              $sformatf("vsync_l%0d", l));

    repeat (4) drive(12'd0, 12'd1279, 1'b0, 1'b0, 12'hFFF, "pre_reset");
    #2 reset = 1'b1;
    #1;
    check("midline_rst_rgb", {20'd0, red, green, blue}, 32'h000);
    check("midline_rst_sync", {30'd0, hsync, vsync}, 32'h3);
    check("midline_rst_font_addr", {20'd0, font_addr}, 32'h0);
    @(negedge clk108);
    check("rst_hold_rgb", {20'd0, red, green, blue}, 32'h000);
    reset = 1'b0;
    seed_tail();

    cursor_row = 6'd63;
    cursor_col = 8'd159;
    cursor_en  = 1'b1;
    cursor_frame(1'b1, "cur_f0");
    vs_ticks(15);
    cursor_frame(1'b1, "cur_f15");
    vs_ticks(1);
    cursor_frame(1'b0, "cur_f16");
    vs_ticks(15);
    cursor_frame(1'b0, "cur_f31");
    vs_ticks(1);
    cursor_frame(1'b1, "cur_f32");
    cursor_en = 1'b0;
    cursor_frame(1'b0, "cur_off");

    repeat (3) drive(12'd1030, 12'd1300, 1'b1, 1'b1, 12'h000, "flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
